// File: rtl/dart_match_ctrl.sv
// N-player dart match controller: decodes each strike, scores it against the active player and rotates turns.
// Optional feature: define DART_DOUBLE_OUT_EN to require a double or bull on the finishing dart.
module dart_match_ctrl #(
   parameter int NUM_PLAYERS    = 2,
   parameter int START_SCORE    = 501,
   parameter int SCORE_W        = 9,
   parameter int DARTS_PER_TURN = 3,
   localparam int PW            = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               dart_come_i,
   input  logic [3:0]         dart_position_x_i,
   input  logic [3:0]         dart_position_y_i,
   input  logic [PW-1:0]      score_sel_i,
   output logic [SCORE_W-1:0] score_o,
   output logic               dart_ready_o,
   output logic [PW-1:0]      cur_player_o,
   output logic [5:0]         dart_point_o,
   output logic               player_done_o,
   output logic               bust_o,
   output logic               game_set_o,
   output logic [PW-1:0]      winner_o
);

   typedef enum logic [2:0] {
      S_INIT,
      S_WAIT,
      S_LOOKUP,
      S_APPLY,
      S_TURN_DONE,
      S_RESULT,
      S_FINISH
   } state_t;

   state_t                    state_q, state_d;
   logic [SCORE_W-1:0]        score_q [NUM_PLAYERS];
   logic [SCORE_W-1:0]        score_d [NUM_PLAYERS];
   logic [SCORE_W-1:0]        turn_start_q, turn_start_d;
   logic [PW-1:0]             cur_player_q, cur_player_d;
   logic [2:0]                dart_cnt_q, dart_cnt_d;
   logic [3:0]                x_q, x_d;
   logic [3:0]                y_q, y_d;
   logic [5:0]                dart_point_q, dart_point_d;
   logic [PW-1:0]             winner_q, winner_d;
   logic                      ready_q, done_q, bust_q, set_q;
   logic                      bust;
   logic [PW-1:0]             next_player;
   logic [SCORE_W:0]          point_ext;
   logic signed [SCORE_W:0]   rem;

   // Board geometry: column x picks segment 2x+2, row y picks the ring.
   function automatic logic [5:0] decode_point(input logic [3:0] x, input logic [3:0] y);
      logic [5:0] seg;
      seg = {1'b0, x, 1'b0} + 6'd2;
      if (x > 4'd9 || y > 4'd9)
         decode_point = 6'd0;
      else if (y == 4'd0)
         decode_point = 6'd50;
      else if (y <= 4'd2)
         decode_point = {seg[4:0], 1'b0};
      else if (y <= 4'd4)
         decode_point = seg + {seg[4:0], 1'b0};
      else
         decode_point = seg;
   endfunction

`ifdef DART_DOUBLE_OUT_EN
   function automatic logic is_double(input logic [3:0] x, input logic [3:0] y);
      is_double = (x <= 4'd9) && (y <= 4'd2);
   endfunction
`endif

   always_comb begin
      next_player = (cur_player_q == PW'(NUM_PLAYERS - 1)) ? '0 : cur_player_q + 1'b1;
      point_ext   = (SCORE_W + 1)'(dart_point_q);
      rem         = $signed({1'b0, score_q[cur_player_q]}) - $signed(point_ext);
   end

   always_comb begin
      state_d      = state_q;
      score_d      = score_q;
      turn_start_d = turn_start_q;
      cur_player_d = cur_player_q;
      dart_cnt_d   = dart_cnt_q;
      x_d          = x_q;
      y_d          = y_q;
      dart_point_d = dart_point_q;
      winner_d     = winner_q;
      bust         = 1'b0;

      case (state_q)
         S_INIT: begin
            for (int i = 0; i < NUM_PLAYERS; i++)
               score_d[i] = SCORE_W'(START_SCORE);
            turn_start_d = SCORE_W'(START_SCORE);
            cur_player_d = '0;
            dart_cnt_d   = '0;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            if (dart_come_i) begin
               x_d     = dart_position_x_i;
               y_d     = dart_position_y_i;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            dart_point_d = decode_point(x_q, y_q);
            state_d      = S_APPLY;
         end
         S_APPLY: begin
            if (rem[SCORE_W])
               bust = 1'b1;
`ifdef DART_DOUBLE_OUT_EN
            else if (rem == '0 && !is_double(x_q, y_q))
               bust = 1'b1;
            else if (rem == (SCORE_W + 1)'(1))
               bust = 1'b1;
`endif

            if (bust) begin
               score_d[cur_player_q] = turn_start_q;
               state_d               = S_TURN_DONE;
            end else if (rem == '0) begin
               score_d[cur_player_q] = '0;
               winner_d              = cur_player_q;
               state_d               = S_RESULT;
            end else begin
               score_d[cur_player_q] = rem[SCORE_W-1:0];
               dart_cnt_d            = dart_cnt_q + 3'd1;
               state_d = (dart_cnt_q == 3'(DARTS_PER_TURN - 1)) ? S_TURN_DONE : S_WAIT;
            end
         end
         S_TURN_DONE: begin
            cur_player_d = next_player;
            dart_cnt_d   = '0;
            turn_start_d = score_q[next_player];
            state_d      = S_WAIT;
         end
         S_RESULT: state_d = S_FINISH;
         S_FINISH: state_d = S_FINISH;
         default:  state_d = S_INIT;
      endcase
   end

   // Status outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_INIT;
         for (int i = 0; i < NUM_PLAYERS; i++)
            score_q[i] <= '0;
         turn_start_q <= '0;
         cur_player_q <= '0;
         dart_cnt_q   <= '0;
         x_q          <= '0;
         y_q          <= '0;
         dart_point_q <= '0;
         winner_q     <= '0;
         ready_q      <= 1'b0;
         done_q       <= 1'b0;
         bust_q       <= 1'b0;
         set_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         score_q      <= score_d;
         turn_start_q <= turn_start_d;
         cur_player_q <= cur_player_d;
         dart_cnt_q   <= dart_cnt_d;
         x_q          <= x_d;
         y_q          <= y_d;
         dart_point_q <= dart_point_d;
         winner_q     <= winner_d;
         ready_q      <= (state_d == S_WAIT);
         done_q       <= (state_d == S_TURN_DONE);
         bust_q       <= bust;
         set_q        <= (state_d == S_RESULT);
      end
   end

   always_comb begin
      score_o = '0;
      if (int'(score_sel_i) < NUM_PLAYERS)
         score_o = score_q[score_sel_i];
   end

   assign dart_ready_o  = ready_q;
   assign cur_player_o  = cur_player_q;
   assign dart_point_o  = dart_point_q;
   assign player_done_o = done_q;
   assign bust_o        = bust_q;
   assign game_set_o    = set_q;
   assign winner_o      = winner_q;

endmodule

// File: tb/tb_dart_match_ctrl.sv
// Directed bench for dart_match_ctrl: 3 players, start score 60, 3 darts per turn.
module tb_dart_match_ctrl;

   localparam int NP = 3;
   localparam int PW = 2;
   localparam int SW = 9;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          dart_come_i = 1'b0;
   logic [3:0]    dart_x = '0;
   logic [3:0]    dart_y = '0;
   logic [PW-1:0] score_sel = '0;
   logic [SW-1:0] score_o;
   logic          dart_ready_o;
   logic [PW-1:0] cur_player_o;
   logic [5:0]    dart_point_o;
   logic          player_done_o;
   logic          bust_o;
   logic          game_set_o;
   logic [PW-1:0] winner_o;

   int checks = 0;
   int failures = 0;

   dart_match_ctrl #(
      .NUM_PLAYERS(NP), .START_SCORE(60), .SCORE_W(SW), .DARTS_PER_TURN(3)
   ) dut (
      .clk(clk), .reset(reset), .dart_come_i(dart_come_i),
      .dart_position_x_i(dart_x), .dart_position_y_i(dart_y),
      .score_sel_i(score_sel), .score_o(score_o), .dart_ready_o(dart_ready_o),
      .cur_player_o(cur_player_o), .dart_point_o(dart_point_o),
      .player_done_o(player_done_o), .bust_o(bust_o),
      .game_set_o(game_set_o), .winner_o(winner_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk_score(input string tag, input logic [PW-1:0] p, input int expv);
      score_sel = p;
      #1;
      chk(tag, 32'(score_o), expv);
      score_sel = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Leaves the bench in the cycle three edges after the dart was accepted.
   task automatic throw(input logic [3:0] x, input logic [3:0] y);
      int n;
      n = 0;
      while (dart_ready_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("ready_before_throw", 32'(dart_ready_o), 1);
      dart_come_i = 1'b1;
      dart_x = x;
      dart_y = y;
      tick();
      dart_come_i = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      // reset state
      reset = 1'b1;
      tick();
      tick();
      chk("rst_ready", 32'(dart_ready_o), 0);
      chk("rst_cur", 32'(cur_player_o), 0);
      chk("rst_point", 32'(dart_point_o), 0);
      chk("rst_done", 32'(player_done_o), 0);
      chk("rst_set", 32'(game_set_o), 0);
      chk("rst_winner", 32'(winner_o), 0);
      chk_score("rst_score0", 0, 0);
      reset = 1'b0;
      tick();
      chk("init_ready", 32'(dart_ready_o), 1);
      chk_score("init_score0", 0, 60);

      // three misses end the turn without scoring
      throw(4'd15, 4'd0);
      chk("miss1_done", 32'(player_done_o), 0);
      chk("miss1_point", 32'(dart_point_o), 0);
      throw(4'd15, 4'd4);
      chk("miss2_done", 32'(player_done_o), 0);
      throw(4'd2, 4'd10);
      chk("miss3_done", 32'(player_done_o), 1);
      chk("miss3_bust", 32'(bust_o), 0);
      chk_score("miss3_score0", 0, 60);
      tick();
      chk("miss_done_pulse", 32'(player_done_o), 0);
      chk("miss_cur", 32'(cur_player_o), 1);

      // normal turn 20 + 30 + 2
      do_reset();
      throw(4'd9, 4'd6);
      chk("t2_pt1", 32'(dart_point_o), 20);
      chk_score("t2_s1", 0, 40);
      chk("t2_done1", 32'(player_done_o), 0);
      throw(4'd4, 4'd3);
      chk("t2_pt2", 32'(dart_point_o), 30);
      chk_score("t2_s2", 0, 10);
      throw(4'd0, 4'd9);
      chk("t2_pt3", 32'(dart_point_o), 2);
      chk_score("t2_s3", 0, 8);
      chk("t2_done", 32'(player_done_o), 1);
      chk("t2_bust", 32'(bust_o), 0);
      tick();
      chk("t2_cur", 32'(cur_player_o), 1);

      // rotation p1 -> p2 -> p0
      for (int i = 0; i < 3; i++) throw(4'd15, 4'd1);
      chk("rot_p1_done", 32'(player_done_o), 1);
      tick();
      chk("rot_cur2", 32'(cur_player_o), 2);
      chk_score("rot_s1", 1, 60);
      for (int i = 0; i < 3; i++) throw(4'd12, 4'd7);
      chk("rot_p2_done", 32'(player_done_o), 1);
      tick();
      chk("rot_cur0", 32'(cur_player_o), 0);

      // p0 at 8 throws triple 20: bust after one dart, score back to 8
      throw(4'd9, 4'd3);
      chk("b1_point", 32'(dart_point_o), 60);
      chk("b1_done", 32'(player_done_o), 1);
      chk("b1_bust", 32'(bust_o), 1);
      chk_score("b1_score", 0, 8);
      tick();
      chk("b1_cur", 32'(cur_player_o), 1);
      chk("b1_bust_pulse", 32'(bust_o), 0);

      // bull then overshoot: restored to 60 after dart 2
      do_reset();
      throw(4'd0, 4'd0);
      chk("b2_bull", 32'(dart_point_o), 50);
      chk_score("b2_s1", 0, 10);
      throw(4'd9, 4'd3);
      chk("b2_done", 32'(player_done_o), 1);
      chk("b2_bust", 32'(bust_o), 1);
      chk_score("b2_score", 0, 60);

      // p0 wins from 40 with double 20
      do_reset();
      throw(4'd9, 4'd6);
      chk_score("w0_s1", 0, 40);
      throw(4'd9, 4'd1);
      chk("w0_point", 32'(dart_point_o), 40);
      chk("w0_set", 32'(game_set_o), 1);
      chk("w0_done", 32'(player_done_o), 0);
      chk("w0_winner", 32'(winner_o), 0);
      chk_score("w0_score", 0, 0);
      tick();
      chk("w0_set_pulse", 32'(game_set_o), 0);
      chk("w0_ready_fin", 32'(dart_ready_o), 0);
      dart_come_i = 1'b1;
      dart_x = 4'd9;
      dart_y = 4'd3;
      tick();
      tick();
      tick();
      dart_come_i = 1'b0;
      tick();
      chk("fin_ready", 32'(dart_ready_o), 0);
      chk("fin_point", 32'(dart_point_o), 40);
      chk("fin_done", 32'(player_done_o), 0);
      chk("fin_set", 32'(game_set_o), 0);
      chk_score("fin_score", 0, 0);

      // p1 wins with a triple 20 on the first dart of its turn
      do_reset();
      for (int i = 0; i < 3; i++) throw(4'd15, 4'd0);
      tick();
      chk("w1_cur", 32'(cur_player_o), 1);
      throw(4'd9, 4'd3);
      chk("w1_set", 32'(game_set_o), 1);
      chk("w1_winner", 32'(winner_o), 1);
      chk_score("w1_s1", 1, 0);
      chk_score("w1_s0", 0, 60);

      // reset mid-turn discards progress
      do_reset();
      throw(4'd9, 4'd6);
      chk_score("mr_s1", 0, 40);
      reset = 1'b1;
      tick();
      chk_score("mr_rst_score", 0, 0);
      chk("mr_rst_ready", 32'(dart_ready_o), 0);
      reset = 1'b0;
      tick();
      chk_score("mr_s0", 0, 60);
      chk_score("mr_s1b", 1, 60);
      chk_score("mr_s2", 2, 60);
      chk("mr_cur", 32'(cur_player_o), 0);
      chk("mr_ready", 32'(dart_ready_o), 1);

`ifdef DART_DOUBLE_OUT_EN
      // single finish is a bust under double-out
      do_reset();
      throw(4'd9, 4'd6);
      throw(4'd9, 4'd6);
      chk_score("do_s2", 0, 20);
      throw(4'd9, 4'd6);
      chk("do_single_set", 32'(game_set_o), 0);
      chk("do_single_done", 32'(player_done_o), 1);
      chk("do_single_bust", 32'(bust_o), 1);
      chk_score("do_single_score", 0, 60);
      do_reset();
      throw(4'd9, 4'd6);
      throw(4'd9, 4'd6);
      throw(4'd4, 4'd1);
      chk("do_dbl_point", 32'(dart_point_o), 20);
      chk("do_dbl_set", 32'(game_set_o), 1);
      chk("do_dbl_winner", 32'(winner_o), 0);
      chk_score("do_dbl_score", 0, 0);
`else
      // any exact finish wins, including a single
      do_reset();
      throw(4'd9, 4'd6);
      throw(4'd9, 4'd6);
      chk_score("so_s2", 0, 20);
      throw(4'd9, 4'd6);
      chk("so_set", 32'(game_set_o), 1);
      chk("so_done", 32'(player_done_o), 0);
      chk("so_bust", 32'(bust_o), 0);
      chk_score("so_score", 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
